// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline memory stage: data-memory req/ack access and write-back register
module memory_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exe_valid,
    input  logic [31:0] alu_result_reg,
    input  logic        exe_wen,
    input  logic [4:0]  exe_regsrc,
    input  logic        exe_is_load,
    input  logic        exe_is_store,
    input  logic [31:0] exe_store_data,
    output logic        mem_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_ack,
    input  logic [31:0] data_rdata,
    output logic        wb_wen,
    output logic [4:0]  wb_regsrc,
    output logic [31:0] wb_wdata,
    output logic        mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [4:0]  pend_regsrc;
    logic        pend_wen;
    logic        memop;
    logic        expiring;

    assign memop    = exe_valid & (exe_is_load | exe_is_store);
    assign expiring = (state == S_WAIT) & ~data_ack & (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (memop) state_nxt = S_WAIT;
            S_WAIT:  if (data_ack || expiring) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stall drops in the retiring cycle so upstream advances on the same edge.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            S_IDLE:  mem_stall = memop;
            S_WAIT:  mem_stall = ~data_ack & ~expiring;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_addr   <= '0;
            data_wdata  <= '0;
            wb_wen      <= 1'b0;
            wb_regsrc   <= '0;
            wb_wdata    <= '0;
            mem_err     <= 1'b0;
            cnt         <= '0;
            pend_regsrc <= '0;
            pend_wen    <= 1'b0;
        end else begin
            wb_wen <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (memop) begin
                        data_req    <= 1'b1;
                        // Load+store together is treated as a load.
                        data_wr     <= exe_is_store & ~exe_is_load;
                        data_addr   <= alu_result_reg;
                        data_wdata  <= exe_store_data;
                        pend_regsrc <= exe_regsrc;
                        pend_wen    <= exe_wen;
                        cnt         <= '0;
                    end else if (exe_valid) begin
                        wb_wen    <= exe_wen & (exe_regsrc != 5'd0);
                        wb_regsrc <= exe_regsrc;
                        wb_wdata  <= alu_result_reg;
                    end
                end
                S_WAIT: begin
                    if (data_ack) begin
                        data_req <= 1'b0;
                        if (!data_wr) begin
                            wb_wen    <= pend_wen & (pend_regsrc != 5'd0);
                            wb_regsrc <= pend_regsrc;
                            wb_wdata  <= data_rdata;
                        end
                    end else if (expiring) begin
                        data_req <= 1'b0;
                        mem_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    data_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - directed bench for memory_stage with write-back scoreboard
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exe_valid;
    logic [31:0] alu_result_reg;
    logic        exe_wen;
    logic [4:0]  exe_regsrc;
    logic        exe_is_load;
    logic        exe_is_store;
    logic [31:0] exe_store_data;
    logic        mem_stall;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;
    logic        wb_wen;
    logic [4:0]  wb_regsrc;
    logic [31:0] wb_wdata;
    logic        mem_err;

    int n_checks = 0;
    int n_fails  = 0;
    logic [36:0] wb_q[$];

    memory_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn), .exe_valid(exe_valid),
        .alu_result_reg(alu_result_reg), .exe_wen(exe_wen), .exe_regsrc(exe_regsrc),
        .exe_is_load(exe_is_load), .exe_is_store(exe_is_store),
        .exe_store_data(exe_store_data), .mem_stall(mem_stall), .data_req(data_req),
        .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_ack(data_ack), .data_rdata(data_rdata), .wb_wen(wb_wen),
        .wb_regsrc(wb_regsrc), .wb_wdata(wb_wdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then score any write-back that retired on that edge.
    task automatic tick();
        logic [36:0] exp;
        @(posedge clk);
        #1;
        if (wb_wen === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("unexpected_wb", {wb_regsrc, wb_wdata}, 37'h0);
            end else begin
                exp = wb_q.pop_front();
                check("wb_triple", {wb_regsrc, wb_wdata}, exp);
            end
        end
    endtask

    task automatic drive_idle();
        exe_valid = 1'b0; exe_is_load = 1'b0; exe_is_store = 1'b0; exe_wen = 1'b0;
        exe_regsrc = '0; alu_result_reg = '0; exe_store_data = '0;
    endtask

    task automatic drive_mem(input logic ld, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] rd, input logic wen);
        exe_valid = 1'b1; exe_is_load = ld; exe_is_store = ~ld; alu_result_reg = addr;
        exe_store_data = wd; exe_regsrc = rd; exe_wen = wen;
    endtask

    initial begin
        resetn = 1'b0; data_ack = 1'b0; data_rdata = '0;
        drive_idle();
        #12;
        check("rst_data_req", 37'(data_req), 37'd0);
        check("rst_wb_wen", 37'(wb_wen), 37'd0);
        check("rst_mem_err", 37'(mem_err), 37'd0);
        check("rst_data_addr", 37'(data_addr), 37'd0);
        check("rst_wb_wdata", 37'(wb_wdata), 37'd0);
        check("rst_mem_stall", 37'(mem_stall), 37'd0);
        resetn = 1'b1;
        tick();

        // ALU pass-through
        exe_valid = 1'b1; alu_result_reg = 32'h12345678; exe_wen = 1'b1; exe_regsrc = 5'd5;
        #1 check("alu_stall", 37'(mem_stall), 37'd0);
        wb_q.push_back({5'd5, 32'h12345678});
        tick();
        check("alu_wb_wen", 37'(wb_wen), 37'd1);
        drive_idle();
        tick();
        check("alu_wb_pulse", 37'(wb_wen), 37'd0);

        // Load with ack in the third request cycle
        drive_mem(1'b1, 32'h100, 32'h0, 5'd7, 1'b1);
        #1 check("ld_accept_stall", 37'(mem_stall), 37'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_req", 37'(data_req), 37'd1);
            check("ld_wr", 37'(data_wr), 37'd0);
            check("ld_addr", 37'(data_addr), 37'h100);
            if (i == 2) begin
                data_ack = 1'b1; data_rdata = 32'hDEADBEEF;
                wb_q.push_back({5'd7, 32'hDEADBEEF});
                #1 check("ld_ack_stall", 37'(mem_stall), 37'd0);
            end else begin
                check("ld_wait_stall", 37'(mem_stall), 37'd1);
            end
        end
        tick();
        data_ack = 1'b0; drive_idle();
        check("ld_req_drop", 37'(data_req), 37'd0);
        check("ld_wb_wen", 37'(wb_wen), 37'd1);

        // Store with immediate ack
        drive_mem(1'b0, 32'h200, 32'hCAFEF00D, 5'd3, 1'b1);
        tick();
        check("st_req", 37'(data_req), 37'd1);
        check("st_wr", 37'(data_wr), 37'd1);
        check("st_wdata", 37'(data_wdata), 37'hCAFEF00D);
        check("st_addr", 37'(data_addr), 37'h200);
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0; drive_idle();
        check("st_req_drop", 37'(data_req), 37'd0);
        check("st_no_wb", 37'(wb_wen), 37'd0);

        // Load to x0 completes but never writes back
        drive_mem(1'b1, 32'h300, 32'h0, 5'd0, 1'b1);
        tick();
        check("x0_req", 37'(data_req), 37'd1);
        data_ack = 1'b1; data_rdata = 32'h55;
        tick();
        data_ack = 1'b0; drive_idle();
        check("x0_no_wb", 37'(wb_wen), 37'd0);
        check("x0_req_drop", 37'(data_req), 37'd0);

        // Timeout: request held exactly TIMEOUT=4 cycles
        drive_mem(1'b1, 32'h400, 32'h0, 5'd9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("to_req", 37'(data_req), 37'd1);
            check("to_err_low", 37'(mem_err), 37'd0);
            check("to_stall", 37'(mem_stall), (i == 3) ? 37'd0 : 37'd1);
        end
        tick();
        drive_idle();
        check("to_req_drop", 37'(data_req), 37'd0);
        check("to_err", 37'(mem_err), 37'd1);
        check("to_no_wb", 37'(wb_wen), 37'd0);
        exe_valid = 1'b1; alu_result_reg = 32'hA5A5A5A5; exe_wen = 1'b1; exe_regsrc = 5'd10;
        wb_q.push_back({5'd10, 32'hA5A5A5A5});
        tick();
        drive_idle();
        check("to_alu_wb", 37'(wb_wen), 37'd1);
        check("to_err_sticky", 37'(mem_err), 37'd1);

        // Reset in the middle of a pending load
        drive_mem(1'b1, 32'h500, 32'h0, 5'd11, 1'b1);
        tick();
        check("rw_req", 37'(data_req), 37'd1);
        drive_idle();
        resetn = 1'b0;
        #1;
        check("rw_req_async", 37'(data_req), 37'd0);
        check("rw_wb_async", 37'(wb_wen), 37'd0);
        check("rw_err_clr", 37'(mem_err), 37'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive_mem(1'b1, 32'h600, 32'h0, 5'd12, 1'b1);
        #1 check("rw_accept_stall", 37'(mem_stall), 37'd1);
        tick();
        check("rw_new_addr", 37'(data_addr), 37'h600);
        data_ack = 1'b1; data_rdata = 32'h13579BDF;
        wb_q.push_back({5'd12, 32'h13579BDF});
        tick();
        data_ack = 1'b0; drive_idle();
        check("rw_new_wb", 37'(wb_wen), 37'd1);
        tick();
        check("sb_empty", 37'(wb_q.size()), 37'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Fourth pipeline stage of the 5-stage CPU. Consumes the registered execute-stage outputs (ALU result, write-enable, destination register, load/store flags), performs the data-memory access over a req/ack handshake, and presents the write-back triple to the register file. Non-memory instructions pass through with one cycle of latency. Loads and stores stall the upstream pipeline until the memory acknowledges or a timeout fires.

## Interface
Parameters:
- TIMEOUT, default 255: maximum number of WAIT cycles without `data_ack` before the access is abandoned (1..255).

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `exe_valid`  in  1  an instruction is present on the `exe_*` inputs.
- `alu_result_reg`  in  32  ALU result; the memory address for loads and stores.
- `exe_wen`  in  1  the instruction writes a register.
- `exe_regsrc`  in  5  destination register number.
- `exe_is_load`  in  1  the instruction is a word load.
- `exe_is_store`  in  1  the instruction is a word store.
- `exe_store_data`  in  32  store data.
- `mem_stall`  out  1  combinational; the upstream stage must hold all `exe_*` inputs stable while this is high.
- `data_req`  out  1  memory request; registered.
- `data_wr`  out  1  1 = write, 0 = read; valid while `data_req` is high.
- `data_addr`  out  32  word address, copied unmodified from `alu_result_reg`.
- `data_wdata`  out  32  write data.
- `data_ack`  in  1  memory completes the request this cycle.
- `data_rdata`  in  32  read data; valid when `data_ack` is high.
- `wb_wen`  out  1  register-file write enable; registered.
- `wb_regsrc`  out  5  register-file write address.
- `wb_wdata`  out  32  register-file write data.
- `mem_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Two states: IDLE and WAIT. Reset puts the block in IDLE.
- Define `memop = exe_valid & (exe_is_load | exe_is_store)`. Load and store asserted together is illegal; treat it as a load.
- IDLE, `exe_valid & ~memop`:
  - Register `wb_wen <= exe_wen & (exe_regsrc != 0)`, `wb_regsrc <= exe_regsrc`, `wb_wdata <= alu_result_reg`.
  - Stay in IDLE.
- IDLE, `memop`:
  - Latch address, write data, `data_wr = exe_is_store`, `exe_regsrc` and `exe_wen`.
  - Set `data_req <= 1`, clear the timeout counter, go to WAIT.
  - `wb_wen <= 0`.
- IDLE, `~exe_valid`: `wb_wen <= 0`.
- WAIT:
  - `data_req`, `data_wr`, `data_addr` and `data_wdata` stay constant.
  - `data_ack` seen, load: `wb_wen <= latched wen & (regsrc != 0)`, `wb_wdata <= data_rdata`. Then `data_req <= 0` and go to IDLE.
  - `data_ack` seen, store: `wb_wen <= 0`. Then `data_req <= 0` and go to IDLE.
  - No ack: increment the counter. `wb_wen <= 0`.
  - Counter reaches TIMEOUT-1 with no ack: `data_req <= 0`, `mem_err <= 1`, `wb_wen <= 0`, go to IDLE. A load that times out writes back nothing.
- `mem_stall = (IDLE & memop) | (WAIT & ~data_ack & ~timeout_expiring)`. It drops in the ack or expiry cycle, so upstream advances on the same edge that retires the access.
- `exe_*` inputs are ignored in WAIT. `data_ack` is ignored in IDLE.
- Reset mid-WAIT: `data_req` drops immediately (asynchronous). The access is abandoned and no write-back occurs.
- Reset values: state IDLE; `data_req`, `data_wr`, `wb_wen`, `mem_err` = 0; `data_addr`, `data_wdata`, `wb_regsrc`, `wb_wdata` = 0; counter 0.

## Timing
- ALU instruction accepted in cycle N: `wb_*` valid in cycle N+1.
- Load or store accepted in cycle N (stall high in N):
  - `data_req` high from N+1.
  - Ack in cycle M ≥ N+1: `data_req` low at M+1, load `wb_*` valid at M+1, next instruction accepted at M+1.
  - Minimum load-to-write-back latency is 2 cycles.
- Timeout: with no ack, `data_req` is high for exactly TIMEOUT cycles. `mem_err` rises on the cycle after the last of them.
- `wb_wen` is a one-cycle pulse per retiring instruction. It is never high for two cycles due to one instruction.
- Back-to-back memory operations: the second one is accepted in the cycle after the first retires, so there is one IDLE cycle between requests. `data_req` is low for at least 1 cycle between requests.

## Test plan
- ALU op: `exe_valid=1`, `alu_result_reg=0x12345678`, `exe_wen=1`, `exe_regsrc=5` → next cycle `wb_wen=1`, `wb_regsrc=5`, `wb_wdata=0x12345678`; `mem_stall` stays 0.
- Load, ack after 3 cycles:
  - Stimulus: address 0x100; memory returns 0xDEADBEEF.
  - Required: `data_req=1`, `data_wr=0`, `data_addr=0x100` for 3 cycles; `mem_stall` high from the accept cycle through the cycle before the ack.
  - Required: `wb_wdata=0xDEADBEEF` and `wb_regsrc` correct one cycle after the ack.
- Store, immediate ack: address 0x200, data 0xCAFEF00D → `data_wr=1`, `data_wdata=0xCAFEF00D` for 1 cycle; `wb_wen` never rises.
- Load with `exe_regsrc=0` → the access completes normally and `wb_wen` stays 0.
- Timeout with TIMEOUT=4 and no ack → `data_req` high 4 cycles, then `mem_err=1` (sticky) and no write-back; a following ALU op writes back normally.
- Reset mid-WAIT: `resetn` low while `data_req=1` → `data_req` and `wb_wen` go to 0 without waiting for a clock edge; after release the block is IDLE and a new load completes normally.
